// File: rtl/teleport_array.sv
// teleport_array: several portals with a shared animated sprite. Detects kid
// contact once per frame, pulses a teleport request with the destination,
// raises a sticky goal flag for the final portal and supplies the sprite-ROM
// address for the pixel being drawn.
module teleport_array #(
  parameter int NUM_PORTALS = 4,
  parameter int SIZE        = 32,
  parameter int ADDR_W      = 25,
  parameter int SPRITE_BASE = 76736,
  parameter int ANIM_FRAMES = 4,
  parameter int ANIM_DIV    = 8,
  parameter int COOLDOWN    = 30,
  parameter int FINAL_IDX   = NUM_PORTALS - 1,
  parameter int HIT_DX      = 10,
  parameter int HIT_DY      = 15
) (
  input  logic                     frame_clk,
  input  logic                     Reset_h,
  input  logic [10*NUM_PORTALS-1:0] Portal_X,
  input  logic [10*NUM_PORTALS-1:0] Portal_Y,
  input  logic [10*NUM_PORTALS-1:0] Dest_X,
  input  logic [10*NUM_PORTALS-1:0] Dest_Y,
  input  logic [NUM_PORTALS-1:0]    Portal_en,
  input  logic [9:0]               Kid_Position_X,
  input  logic [9:0]               Kid_Position_Y,
  input  logic [9:0]               DrawX_write,
  input  logic [9:0]               DrawY_write,
  output logic                     isTeleport,
  output logic [ADDR_W-1:0]        Teleport_address,
  output logic                     teleport_req,
  output logic [9:0]               Teleport_dest_X,
  output logic [9:0]               Teleport_dest_Y,
  output logic [2:0]               portal_id,
  output logic                     reach_final
);

  localparam int DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int ANIM_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int COOL_W = $clog2(COOLDOWN + 1);
  localparam int CALC_W = (ADDR_W > 32) ? ADDR_W : 32;

  typedef enum logic {READY, COOL} state_t;

  state_t              state, state_next;
  logic [COOL_W-1:0]   cool_cnt, cool_next;
  logic [DIV_W-1:0]    div_cnt;
  logic [ANIM_W-1:0]   anim;

  logic                req_next, final_next;
  logic [9:0]          dest_x_next, dest_y_next;
  logic [2:0]          id_next;

  logic                kid_hit;
  logic [2:0]          kid_idx;
  logic [9:0]          kid_dest_x, kid_dest_y;
  logic [10:0]         hot_x, hot_y;

  logic                draw_hit;
  logic [10:0]         win_px, win_py;
  logic [10:0]         draw_dx, draw_dy;
  logic [CALC_W-1:0]   addr_full;

  // Hotspot is widened to 11 bits so portals near the right/bottom edge never wrap
  assign hot_x = {1'b0, Kid_Position_X} + 11'(HIT_DX);
  assign hot_y = {1'b0, Kid_Position_Y} + 11'(HIT_DY);

  // Kid contact search; scanning downward lets the lowest enabled index win
  always_comb begin
    logic [10:0] px, py;
    kid_hit    = 1'b0;
    kid_idx    = 3'd0;
    kid_dest_x = 10'd0;
    kid_dest_y = 10'd0;
    px         = 11'd0;
    py         = 11'd0;
    for (int i = NUM_PORTALS - 1; i >= 0; i--) begin
      px = {1'b0, Portal_X[10*i +: 10]};
      py = {1'b0, Portal_Y[10*i +: 10]};
      if (Portal_en[i] &&
          hot_x >= px && hot_x <= px + 11'(SIZE - 1) &&
          hot_y >= py && hot_y <= py + 11'(SIZE - 1)) begin
        kid_hit    = 1'b1;
        kid_idx    = 3'(i);
        kid_dest_x = Dest_X[10*i +: 10];
        kid_dest_y = Dest_Y[10*i +: 10];
      end
    end
  end

  // Draw-pixel search with the same lowest-index priority, picking the origin for dx/dy
  always_comb begin
    logic [10:0] px, py, dx11, dy11;
    draw_hit = 1'b0;
    win_px   = 11'd0;
    win_py   = 11'd0;
    px       = 11'd0;
    py       = 11'd0;
    dx11     = {1'b0, DrawX_write};
    dy11     = {1'b0, DrawY_write};
    for (int i = NUM_PORTALS - 1; i >= 0; i--) begin
      px = {1'b0, Portal_X[10*i +: 10]};
      py = {1'b0, Portal_Y[10*i +: 10]};
      if (Portal_en[i] &&
          dx11 >= px && dx11 <= px + 11'(SIZE - 1) &&
          dy11 >= py && dy11 <= py + 11'(SIZE - 1)) begin
        draw_hit = 1'b1;
        win_px   = px;
        win_py   = py;
      end
    end
  end

  assign draw_dx   = {1'b0, DrawX_write} - win_px;
  assign draw_dy   = {1'b0, DrawY_write} - win_py;
  assign addr_full = CALC_W'(SPRITE_BASE)
                   + CALC_W'(anim) * CALC_W'(SIZE * SIZE)
                   + CALC_W'(draw_dy) * CALC_W'(SIZE)
                   + CALC_W'(draw_dx);

  assign isTeleport       = draw_hit;
  assign Teleport_address = draw_hit ? addr_full[ADDR_W-1:0] : '0;

  // Free-running animation: divider wraps every ANIM_DIV frames and steps the shared frame index
  always_ff @(posedge frame_clk) begin
    if (Reset_h) begin
      div_cnt <= '0;
      anim    <= '0;
    end else if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
      div_cnt <= '0;
      anim    <= (anim == ANIM_W'(ANIM_FRAMES - 1)) ? '0 : anim + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Control decisions: fire on a normal portal, flag the goal portal, count down while cooling
  always_comb begin
    state_next  = state;
    cool_next   = cool_cnt;
    req_next    = 1'b0;
    dest_x_next = Teleport_dest_X;
    dest_y_next = Teleport_dest_Y;
    id_next     = portal_id;
    final_next  = reach_final;
    case (state)
      READY: begin
        if (kid_hit) begin
          if (kid_idx == 3'(FINAL_IDX)) begin
            final_next = 1'b1;
          end else begin
            req_next    = 1'b1;
            dest_x_next = kid_dest_x;
            dest_y_next = kid_dest_y;
            id_next     = kid_idx;
            cool_next   = COOL_W'(COOLDOWN - 1);
            state_next  = COOL;
          end
        end
      end
      COOL: begin
        if (cool_cnt == '0) begin
          state_next = READY;
        end else begin
          cool_next = cool_cnt - 1'b1;
        end
      end
      default: state_next = READY;
    endcase
  end

  // Registers for state, cooldown and all control outputs; reset clears even mid-cooldown
  always_ff @(posedge frame_clk) begin
    if (Reset_h) begin
      state           <= READY;
      cool_cnt        <= '0;
      teleport_req    <= 1'b0;
      Teleport_dest_X <= 10'd0;
      Teleport_dest_Y <= 10'd0;
      portal_id       <= 3'd0;
      reach_final     <= 1'b0;
    end else begin
      state           <= state_next;
      cool_cnt        <= cool_next;
      teleport_req    <= req_next;
      Teleport_dest_X <= dest_x_next;
      Teleport_dest_Y <= dest_y_next;
      portal_id       <= id_next;
      reach_final     <= final_next;
    end
  end

endmodule

// File: tb/tb_teleport_array.sv
// Testbench for teleport_array: a behavioural reference model pushes the
// expected post-edge outputs into a queue each cycle; they are popped and
// compared one time unit after the clock edge.
module tb_teleport_array;

  localparam int NP   = 4;
  localparam int SZ   = 32;
  localparam int BASE = 76736;
  localparam int COOL = 30;
  localparam int FIN  = 3;

  logic              frame_clk = 1'b0;
  logic              Reset_h;
  logic [10*NP-1:0]  Portal_X, Portal_Y, Dest_X, Dest_Y;
  logic [NP-1:0]     Portal_en;
  logic [9:0]        Kid_Position_X, Kid_Position_Y, DrawX_write, DrawY_write;
  logic              isTeleport;
  logic [24:0]       Teleport_address;
  logic              teleport_req;
  logic [9:0]        Teleport_dest_X, Teleport_dest_Y;
  logic [2:0]        portal_id;
  logic              reach_final;

  teleport_array dut (
    .frame_clk        (frame_clk),
    .Reset_h          (Reset_h),
    .Portal_X         (Portal_X),
    .Portal_Y         (Portal_Y),
    .Dest_X           (Dest_X),
    .Dest_Y           (Dest_Y),
    .Portal_en        (Portal_en),
    .Kid_Position_X   (Kid_Position_X),
    .Kid_Position_Y   (Kid_Position_Y),
    .DrawX_write      (DrawX_write),
    .DrawY_write      (DrawY_write),
    .isTeleport       (isTeleport),
    .Teleport_address (Teleport_address),
    .teleport_req     (teleport_req),
    .Teleport_dest_X  (Teleport_dest_X),
    .Teleport_dest_Y  (Teleport_dest_Y),
    .portal_id        (portal_id),
    .reach_final      (reach_final)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int req; int dx; int dy; int id; int fin; int ist; int addr;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int errors  = 0;

  int px[NP], py[NP], dstx[NP], dsty[NP];
  int m_cool, m_req, m_dx, m_dy, m_id, m_fin, m_div, m_anim;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic loadPortals();
    for (int i = 0; i < NP; i++) begin
      Portal_X[10*i +: 10] = 10'(px[i]);
      Portal_Y[10*i +: 10] = 10'(py[i]);
      Dest_X[10*i +: 10]   = 10'(dstx[i]);
      Dest_Y[10*i +: 10]   = 10'(dsty[i]);
    end
  endtask

  function automatic int inside_portal(input int i, input int x, input int y);
    return (Portal_en[i] && x >= px[i] && x < px[i] + SZ && y >= py[i] && y < py[i] + SZ) ? 1 : 0;
  endfunction

  // Drive one frame of stimulus, predict the post-edge outputs, then check them
  task automatic applyStimulus(input logic rst, input int kx, input int ky, input int drx, input int dry);
    exp_t e, o;
    int k, w;
    Reset_h        = rst;
    Kid_Position_X = 10'(kx);
    Kid_Position_Y = 10'(ky);
    DrawX_write    = 10'(drx);
    DrawY_write    = 10'(dry);
    k = -1;
    for (int i = 0; i < NP; i++)
      if (k < 0 && inside_portal(i, kx + 10, ky + 15) != 0) k = i;
    if (rst) begin
      m_cool = 0; m_req = 0; m_dx = 0; m_dy = 0; m_id = 0; m_fin = 0; m_div = 0; m_anim = 0;
    end else begin
      m_req = 0;
      if (m_cool > 0) m_cool--;
      else if (k == FIN) m_fin = 1;
      else if (k >= 0) begin
        m_req = 1; m_dx = dstx[k]; m_dy = dsty[k]; m_id = k; m_cool = COOL;
      end
      m_div++;
      if (m_div == 8) begin m_div = 0; m_anim = (m_anim + 1) % 4; end
    end
    w = -1;
    for (int i = 0; i < NP; i++)
      if (w < 0 && inside_portal(i, drx, dry) != 0) w = i;
    e.req = m_req; e.dx = m_dx; e.dy = m_dy; e.id = m_id; e.fin = m_fin;
    e.ist  = (w >= 0) ? 1 : 0;
    e.addr = (w >= 0) ? BASE + m_anim * SZ * SZ + (dry - py[w]) * SZ + (drx - px[w]) : 0;
    exp_q.push_back(e);
    @(posedge frame_clk);
    #1;
    o = exp_q.pop_front();
    checkOutput("teleport_req", int'(teleport_req), o.req);
    checkOutput("dest_x", int'(Teleport_dest_X), o.dx);
    checkOutput("dest_y", int'(Teleport_dest_Y), o.dy);
    checkOutput("portal_id", int'(portal_id), o.id);
    checkOutput("reach_final", int'(reach_final), o.fin);
    checkOutput("isTeleport", int'(isTeleport), o.ist);
    checkOutput("address", int'(Teleport_address), o.addr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 900, 700);
  endtask

  initial begin
    px   = '{100, 300, 310, 600};
    py   = '{100, 200, 210, 300};
    dstx = '{500, 10, 30, 0};
    dsty = '{400, 20, 40, 0};
    Portal_en = 4'b1111;
    loadPortals();
    m_cool = 0; m_req = 0; m_dx = 0; m_dy = 0; m_id = 0; m_fin = 0; m_div = 0; m_anim = 0;

    // Reset state
    applyStimulus(1'b1, 0, 0, 900, 700);
    applyStimulus(1'b1, 0, 0, 900, 700);
    checkOutput("reset_req", int'(teleport_req), 0);

    // Hotspot (105,105) on portal 0: one pulse, then 30 suppressed frames, then refire
    applyStimulus(1'b0, 95, 90, 900, 700);
    checkOutput("t1_pulse", int'(teleport_req), 1);
    checkOutput("t1_dest_x", int'(Teleport_dest_X), 500);
    for (int i = 0; i < COOL; i++) begin
      applyStimulus(1'b0, 95, 90, 900, 700);
      checkOutput("t1_suppressed", int'(teleport_req), 0);
    end
    applyStimulus(1'b0, 95, 90, 900, 700);
    checkOutput("t1_refire", int'(teleport_req), 1);
    idle(COOL + 1);

    // Corner hotspots (131,131) and (100,100) hit; (132,100) misses
    applyStimulus(1'b0, 121, 116, 900, 700);
    checkOutput("t2_far_corner", int'(teleport_req), 1);
    idle(COOL + 1);
    applyStimulus(1'b0, 90, 85, 900, 700);
    checkOutput("t2_near_corner", int'(teleport_req), 1);
    idle(COOL + 1);
    applyStimulus(1'b0, 122, 85, 900, 700);
    checkOutput("t2_outside", int'(teleport_req), 0);

    // Overlap of portals 1 and 2: portal 1 wins for kid and for drawing
    applyStimulus(1'b0, 305, 200, 320, 220);
    checkOutput("t3_id", int'(portal_id), 1);
    checkOutput("t3_dest_y", int'(Teleport_dest_Y), 20);
    idle(COOL + 1);

    // Goal portal sets sticky flag without a request; reset clears it
    applyStimulus(1'b0, 600, 295, 900, 700);
    checkOutput("t4_final", int'(reach_final), 1);
    checkOutput("t4_no_req", int'(teleport_req), 0);
    idle(3);
    checkOutput("t4_sticky", int'(reach_final), 1);
    applyStimulus(1'b1, 0, 0, 900, 700);
    checkOutput("t4_cleared", int'(reach_final), 0);

    // Draw address with anim=2 on portal 0, then a pixel off every portal
    for (int i = 0; i < 64 && m_anim != 2; i++) applyStimulus(1'b0, 0, 0, 105, 103);
    checkOutput("t5_address", int'(Teleport_address), 78885);
    applyStimulus(1'b0, 0, 0, 50, 50);
    checkOutput("t5_off_address", int'(Teleport_address), 0);

    // Disabled portal neither triggers nor draws
    Portal_en = 4'b1110;
    applyStimulus(1'b0, 95, 90, 105, 103);
    checkOutput("en_off_req", int'(teleport_req), 0);
    checkOutput("en_off_draw", int'(isTeleport), 0);
    Portal_en = 4'b1111;

    // Reset during cooldown returns to READY; next hit fires immediately
    applyStimulus(1'b0, 95, 90, 900, 700);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 95, 90, 900, 700);
    applyStimulus(1'b1, 95, 90, 900, 700);
    checkOutput("t6_reset_dest", int'(Teleport_dest_X), 0);
    applyStimulus(1'b0, 95, 90, 900, 700);
    checkOutput("t6_fire_after_reset", int'(teleport_req), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
